tft_pixel_feeder: RTL and testbench

- Upstream stage of the ILI9341 8080-I driver.
- Accepts an RGB565 pixel stream from a renderer over a valid/ready handshake and buffers it in a small FIFO.
- Generates the driver's newFrameStrobe and dataReady, and presents the pixel matching the driver's pixelAddr on its pixelDataIn.
- Same clock as the driver (the divided slowClk).

---
 rtl/tft_pkg.sv | 22 ++
 rtl/tft_pixel_fifo.sv | 55 +++++
 rtl/tft_pixel_feeder.sv | 153 +++++++++++++++
 tb/tb_tft_pixel_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared types and frame constants for the ILI9341 pixel path.
// Used by both the pixel feeder and the 8080-I driver.
package tft_pkg;

  localparam int NUM_PIXELS = 76800;
  localparam int NUM_FRAME_START_PARAMS = 11;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic    sof;
    rgb565_t data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    PREAMBLE,
    STREAM
  } feeder_state_t;

endpackage

// File: rtl/tft_pixel_fifo.sv
// Pixel FIFO with head and lookahead read ports.
// ready is registered and already reflects this cycle's push/pop.
module tft_pixel_fifo
  import tft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  fifo_entry_t                wrData,
  output fifo_entry_t                headData,
  output rgb565_t                    nextData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ready,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW-1:0]  rdPtrNext;
  logic [AW:0]    countNext;

  assign rdPtrNext = rdPtr + 1'b1;
  assign headData  = mem[rdPtr];
  assign nextData  = mem[rdPtrNext].data;
  assign empty     = (count == '0);

  always_comb begin
    countNext = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtrNext;
      count <= countNext;
      ready <= (countNext != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/tft_pixel_feeder.sv
// Feeds buffered RGB565 pixels to the ILI9341 driver at zero latency.
// TFT_PIXEL_FEEDER_STATS_EN adds drop_cnt / underrun_cnt outputs.
module tft_pixel_feeder #(
  parameter int DEPTH = 16,
  parameter int NUM_PIXELS = tft_pkg::NUM_PIXELS,
  parameter int NUM_FRAME_START_PARAMS =
    tft_pkg::NUM_FRAME_START_PARAMS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic [16:0] pixel_addr,
  output logic [15:0] pixel_data,
  output logic        data_ready,
  output logic        new_frame_strobe,
`ifdef TFT_PIXEL_FEEDER_STATS_EN
  output logic [15:0] drop_cnt,
  output logic [15:0] underrun_cnt,
  output logic        frame_error
`else
  output logic        frame_error
`endif
);

  import tft_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_PIXELS + 1);

  feeder_state_t state;
  fifo_entry_t   wrData;
  fifo_entry_t   headData;
  rgb565_t       nextData;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          pop;
  logic          addrInc;
  logic          earlySof;
  logic          seenEnd;
  logic          frameError;
  logic [16:0]   addrQ;
  logic [CW-1:0] pixCnt;

  assign wrData  = '{sof: s_sof, data: s_data};
  assign push    = s_valid & s_ready;
  assign addrInc = (pixel_addr == addrQ + 17'd1);

  // a new frame's sof reaching the head mid-frame aborts this frame
  assign earlySof = (state == STREAM) & !empty &
                    headData.sof & (pixCnt != '0);

  tft_pixel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wrData  (wrData),
    .headData(headData),
    .nextData(nextData),
    .count   (count),
    .ready   (s_ready),
    .empty   (empty)
  );

  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:     pop = !empty & !headData.sof;
      STREAM:   pop = addrInc & !empty & !earlySof;
      default:  pop = 1'b0;
    endcase
  end

  always_comb begin
    pixel_data = '0;
    if (state == STREAM)
      pixel_data = addrInc ? nextData : headData.data;
    else if (!empty)
      pixel_data = headData.data;
  end

  assign data_ready = (state == STREAM) &
    ((count >= (AW+1)'(2)) |
     ((pixCnt == CW'(NUM_PIXELS - 1)) & !empty));

  assign new_frame_strobe = (state == STROBE);
  assign frame_error      = frameError;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pixCnt     <= '0;
      addrQ      <= '0;
      seenEnd    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      addrQ      <= pixel_addr;
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          seenEnd <= 1'b0;
          if (!empty && headData.sof) state <= STROBE;
        end
        STROBE: begin
          seenEnd <= 1'b0;
          state   <= PREAMBLE;
        end
        PREAMBLE: begin
          if (pixel_addr == 17'(NUM_FRAME_START_PARAMS))
            seenEnd <= 1'b1;
          if (seenEnd && pixel_addr == '0) begin
            state  <= STREAM;
            pixCnt <= '0;
            addrQ  <= '0;
          end
        end
        STREAM: begin
          if (earlySof) begin
            frameError <= 1'b1;
            state      <= STROBE;
          end else if (pop) begin
            pixCnt <= pixCnt + 1'b1;
            if (pixCnt == CW'(NUM_PIXELS - 1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TFT_PIXEL_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      if (state == IDLE && pop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (state == STREAM && !data_ready &&
          underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tft_pixel_feeder.sv
// Scoreboard bench for tft_pixel_feeder with a behavioural driver.
// Frame size shrunk to 8 pixels; FIFO depth 16.
module tb_tft_pixel_feeder;

  localparam int NPIX = 8;
  localparam int NFSP = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic [15:0] s_data = '0;
  logic [16:0] pixel_addr = '0;
  logic        s_ready;
  logic        data_ready;
  logic        new_frame_strobe;
  logic        frame_error;
  logic [15:0] pixel_data;
`ifdef TFT_PIXEL_FEEDER_STATS_EN
  logic [15:0] drop_cnt;
  logic [15:0] underrun_cnt;
`endif

  int nChecks = 0;
  int nPass = 0;
  int strobeCycles = 0;
  int errCycles = 0;
  int stallCycles = 0;
  logic [15:0] sb[$];

  tft_pixel_feeder #(
    .DEPTH(16),
    .NUM_PIXELS(NPIX),
    .NUM_FRAME_START_PARAMS(NFSP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_sof(s_sof),
    .s_ready(s_ready),
    .pixel_addr(pixel_addr),
    .pixel_data(pixel_data),
    .data_ready(data_ready),
    .new_frame_strobe(new_frame_strobe),
`ifdef TFT_PIXEL_FEEDER_STATS_EN
    .drop_cnt(drop_cnt),
    .underrun_cnt(underrun_cnt),
`endif
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_frame_strobe) strobeCycles++;
    if (frame_error) errCycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  task automatic checkPix(input string tag, input bit popIt);
    logic [31:0] exp;
    exp = 32'hDEAD_BEEF;
    if (sb.size() != 0) begin
      exp = {16'h0, sb[0]};
      if (popIt) void'(sb.pop_front());
    end
    check(tag, {16'h0, pixel_data}, exp);
  endtask

  task automatic push(input logic sof, input logic [15:0] d,
                      input bit keep);
    int t;
    t = 0;
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      check("push_ready", s_ready, 1);
      return;
    end
    s_valid = 1'b1;
    s_sof = sof;
    s_data = d;
    if (keep) sb.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  // driver model: strobe, address preamble, then one pixel
  // per advance, only advancing while data_ready is high
  task automatic runFrame(input int n, input bit trunc,
                          input int delay, input int stopAt);
    int t;
    t = 0;
    while (!new_frame_strobe && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("strobe", new_frame_strobe, 1);
    pixel_addr = '0;
    @(negedge clk);
    check("strobe_1cyc", new_frame_strobe, 0);
    repeat (delay) @(negedge clk);
    for (int a = 1; a <= NFSP; a++) begin
      pixel_addr = 17'(a);
      @(negedge clk);
    end
    pixel_addr = '0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!data_ready && t < 400) begin
        @(negedge clk);
        t++;
        stallCycles++;
      end
      check("data_ready", data_ready, 1);
      if (!data_ready) return;
      checkPix("pix_head", 1'b1);
      if (k == stopAt) return;
      pixel_addr = 17'(k + 1);
      #1;
      if (k < n - 1 || trunc) checkPix("pix_ahead", 1'b0);
      @(negedge clk);
    end
    if (trunc) begin
      t = 0;
      while (!frame_error && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("frame_error", frame_error, 1);
      check("err_strobe", new_frame_strobe, 1);
    end else begin
      check("idle_dr", data_ready, 0);
    end
  endtask

  initial begin
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_dr", data_ready, 0);
    check("rst_strobe", new_frame_strobe, 0);
    check("rst_err", frame_error, 0);
    check("rst_pix", pixel_data, 16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_up", s_ready, 1);

    push(1'b0, 16'h1111, 1'b0);
    push(1'b0, 16'h2222, 1'b0);
    push(1'b0, 16'h3333, 1'b0);
    repeat (3) @(negedge clk);
    check("drop_empty", pixel_data, 16'h0);
    check("drop_no_strobe", strobeCycles, 0);
    check("drop_dr", data_ready, 0);
`ifdef TFT_PIXEL_FEEDER_STATS_EN
    check("drop_cnt", drop_cnt, 3);
`endif

    fork
      begin
        push(1'b1, 16'hF800, 1'b1);
        push(1'b0, 16'h07E0, 1'b1);
        for (int i = 2; i < NPIX; i++)
          push(1'b0, 16'(16'h0100 + i), 1'b1);
      end
      runFrame(NPIX, 1'b0, 0, -1);
    join

    stallCycles = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push(i == 0, 16'(16'h0A00 + i), 1'b1);
        repeat (60) @(negedge clk);
        check("stall_dr", data_ready, 0);
        check("stall_pix", pixel_data, 16'h0A03);
        for (int i = 4; i < NPIX; i++)
          push(1'b0, 16'(16'h0A00 + i), 1'b1);
      end
      runFrame(NPIX, 1'b0, 0, -1);
    join
    check("stalled", stallCycles > 0, 1);
`ifdef TFT_PIXEL_FEEDER_STATS_EN
    check("underrun_nz", underrun_cnt != 0, 1);
`endif

    fork
      begin
        for (int i = 0; i < NPIX; i++)
          push(i == 0, 16'(16'h1000 + i), 1'b1);
        for (int i = 0; i < NPIX; i++)
          push(i == 0, 16'(16'h2000 + i), 1'b1);
        check("full_ready", s_ready, 0);
        for (int i = 0; i < 5; i++)
          push(i == 0, 16'(16'h3000 + i), 1'b1);
        for (int i = 0; i < NPIX; i++)
          push(i == 0, 16'(16'h4000 + i), 1'b1);
      end
      begin
        runFrame(NPIX, 1'b0, 40, -1);
        runFrame(NPIX, 1'b0, 0, -1);
        runFrame(5, 1'b1, 0, -1);
        runFrame(NPIX, 1'b0, 0, -1);
      end
    join
    check("err_pulses", errCycles, 1);
    check("sb_drained", sb.size(), 0);

    fork
      for (int i = 0; i < NPIX; i++)
        push(i == 0, 16'(16'h5000 + i), 1'b1);
      runFrame(NPIX, 1'b0, 0, 3);
    join
    check("dr_live", data_ready, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_dr", data_ready, 0);
    check("arst_strobe", new_frame_strobe, 0);
    check("arst_pix", pixel_data, 16'h0);
    check("arst_s_ready", s_ready, 0);
    check("arst_err", frame_error, 0);
`ifdef TFT_PIXEL_FEEDER_STATS_EN
    check("arst_drop", drop_cnt, 0);
    check("arst_underrun", underrun_cnt, 0);
`endif
    sb.delete();
    pixel_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);
    check("rel_pix", pixel_data, 16'h0);
    check("rel_dr", data_ready, 0);
    push(1'b0, 16'hABCD, 1'b0);
    repeat (2) @(negedge clk);
    check("rel_drop_pix", pixel_data, 16'h0);
    check("strobes", strobeCycles, 7);
`ifdef TFT_PIXEL_FEEDER_STATS_EN
    check("rel_drop_cnt", drop_cnt, 1);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
